vga_gen: RTL
============

VGA_GEN -- requirements
Module: vga_gen

Interface
REQ-001 SHALL have parameters HDISP 800 (active pixels/line), VDISP 480 (active lines/frame), HFP 40, HPULSE 48, HBP 40, VFP 12, VPULSE 3, VBP 40 (porch and sync widths, pixels/lines).
REQ-002 SHALL have parameter HS_POL 0 (HS active level), VS_POL 0 (VS active level), PIPE 2 (external pixel-source latency, legal 0..4).
REQ-003 SHALL have ports: pixel_clk in 1 pixel clock; pixel_rst in 1 reset; reset pixel_rst, asynchronous, active-high; clock pixel_clk.
REQ-004 SHALL have ports: enable in 1 run/stop; mode in 2 pattern select (0 grid, 1 colour bars, 2 external, 3 solid); solid_rgb in 24 solid colour; ext_rgb in 24 external pixel data.
REQ-005 SHALL have ports: req out 1 external pixel request; req_x out clog2(HDISP) requested column; req_y out clog2(VDISP) requested row.
REQ-006 SHALL have ports: vga_clk out 1 (= pixel_clk); vga_hs out 1; vga_vs out 1; vga_blank out 1 (1 = active video); vga_rgb out 24 {R,G,B}; line_start out 1; frame_start out 1.

Function
REQ-007 SHALL keep h counter 0..HTOTAL-1 (HTOTAL=HFP+HPULSE+HBP+HDISP) and v counter 0..VTOTAL-1 (VTOTAL=VFP+VPULSE+VBP+VDISP); h wraps to 0 after HTOTAL-1 and v increments only on that same edge, wrapping to 0 after VTOTAL-1 (no extra line).
REQ-008 SHALL order each line/frame: front porch, sync pulse, back porch, active; HS active for HFP<=h<HFP+HPULSE, VS active for VFP<=v<VFP+VPULSE, active video when h>=HFP+HPULSE+HBP and v>=VFP+VPULSE+VBP.
REQ-009 SHALL define x=h-(HFP+HPULSE+HBP), y=v-(VFP+VPULSE+VBP) in active video, widths truncated to req_x/req_y.
REQ-010 SHALL assert req combinationally from counters exactly while active, with req_x=x, req_y=y; req_x/req_y = 0 when req low.
REQ-011 SHALL sample ext_rgb exactly PIPE cycles after the corresponding req cycle.
REQ-012 SHALL present all video outputs (hs, vs, blank, rgb, line_start, frame_start) registered, PIPE+1 cycles after the counter state they describe, all mutually aligned.
REQ-013 SHALL produce rgb: mode 0: FFFFFF if x%16==0 or y%16==0 else 000000; mode 1: eight bars of width HDISP/8 white, yellow, cyan, green, magenta, red, blue, black (x beyond 8*(HDISP/8) black); mode 2: ext_rgb; mode 3: solid_rgb.
REQ-014 SHALL force vga_rgb=000000 whenever vga_blank=0.
REQ-015 SHALL latch mode only when h=0 and v=0 (frame boundary); a mid-frame mode change takes effect at the next frame; solid_rgb is used live.
REQ-016 SHALL pulse line_start for one cycle aligned with output of h=0, and frame_start for one cycle aligned with output of h=0,v=0 (both high together then).
REQ-017 SHALL, when enable=0, synchronously clear counters to 0, hold req=0, and flush the pipeline so outputs go inactive (hs=!HS_POL, vs=!VS_POL, blank=0, rgb=0, pulses 0) PIPE+1 cycles later; on enable 1 restart at h=0,v=0 with frame_start after PIPE+1 cycles.
REQ-018 SHALL reject illegal PIPE by elaboration-time error.

Reset
REQ-019 SHALL, while pixel_rst=1, immediately force counters 0, latched mode 0, all pipeline stages inactive, vga_hs=!HS_POL, vga_vs=!VS_POL, vga_blank=0, vga_rgb=0, req=0, line_start=0, frame_start=0.
REQ-020 SHALL treat reset asserted mid-frame identically; after release, first edge with enable=1 counts from h=0,v=0.

Verification
REQ-021 Params HDISP=16,VDISP=8,HFP=2,HPULSE=3,HBP=2,VFP=1,VPULSE=2,VBP=1,PIPE=2; release reset, enable=1 -> HTOTAL=23, VTOTAL=12; vga_hs low output edges 5..7, frame_start at edge 3, next frame_start 276 edges later.
REQ-022 Same params, mode 0 -> vga_blank high 16 cycles/line on 8 lines; rgb FFFFFF at x=0 and whole y=0 line, 000000 elsewhere; rgb 0 when blank=0.
REQ-023 Mode 2, ext_rgb driven = {req_y,req_x} delayed 2 cycles -> every active output pixel equals its own {y,x}; PIPE=0 variant also matches.
REQ-024 Switch mode 0->1 mid-frame -> current frame stays grid; next frame shows bars 2 px wide: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-025 Assert pixel_rst mid-active line -> outputs inactive same cycle (no clock edge needed); after release frame_start again at edge 3.
REQ-026 Drop enable mid-frame for 10 cycles -> outputs inactive 3 cycles later, restart from h=0,v=0; HS_POL=1 run inverts vga_hs only.

Source files
------------

// File: rtl/vga_gen.sv
// rtl/vga_gen.sv - VGA timing generator with built-in test patterns and external pixel source
module vga_gen #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 12,
    parameter int VPULSE = 3,
    parameter int VBP    = 40,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int PIPE   = 2
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic [23:0]                solid_rgb,
    input  logic [23:0]                ext_rgb,
    output logic                       req,
    output logic [$clog2(HDISP)-1:0]   req_x,
    output logic [$clog2(VDISP)-1:0]   req_y,
    output logic                       vga_clk,
    output logic                       vga_hs,
    output logic                       vga_vs,
    output logic                       vga_blank,
    output logic [23:0]                vga_rgb,
    output logic                       line_start,
    output logic                       frame_start
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);
    localparam int HSTART = HFP + HPULSE + HBP;
    localparam int VSTART = VFP + VPULSE + VBP;
    localparam int BARW   = HDISP / 8;
    localparam int BARD   = (BARW > 0) ? BARW : 1;
    // Pipeline word: active, hs, vs, line_start, frame_start, mode, x, y
    localparam int SW     = 7 + XW + YW;
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    generate
        if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
            $error("vga_gen: PIPE must be within 0..4");
        end
    endgenerate

    assign vga_clk = pixel_clk;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [1:0]    mode_q;
    logic          h_last;
    logic          v_last;
    logic          active;
    logic          hs_act;
    logic          vs_act;
    logic          at_origin;

    assign h_last    = (h_cnt == HW'(HTOTAL - 1));
    assign v_last    = (v_cnt == VW'(VTOTAL - 1));
    assign active    = (h_cnt >= HW'(HSTART)) && (v_cnt >= VW'(VSTART));
    assign hs_act    = (h_cnt >= HW'(HFP)) && (h_cnt < HW'(HFP + HPULSE));
    assign vs_act    = (v_cnt >= VW'(VFP)) && (v_cnt < VW'(VFP + VPULSE));
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    // Raster counters: h wraps each line, v advances only on the h wrap; disable parks both at 0
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Pattern mode is sampled only at the frame origin so a frame never mixes patterns
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            mode_q <= 2'd0;
        end else if (enable && at_origin) begin
            mode_q <= mode;
        end
    end

    assign req   = active && enable && !pixel_rst;
    assign req_x = req ? XW'(h_cnt - HW'(HSTART)) : '0;
    assign req_y = req ? YW'(v_cnt - VW'(VSTART)) : '0;

    logic [SW-1:0] s0;
    logic [SW-1:0] s_last;

    assign s0 = enable ? {active, hs_act, vs_act, (h_cnt == '0), at_origin, mode_q, req_x, req_y}
                       : '0;

    // Delay line matching the external source latency, so ext_rgb lines up with its request
    generate
        if (PIPE == 0) begin : g_nopipe
            assign s_last = s0;
        end else begin : g_pipe
            logic [SW-1:0] pipe_q [PIPE];

            // Shift the raster description one stage per clock; reset empties every stage
            always_ff @(posedge pixel_clk or posedge pixel_rst) begin
                if (pixel_rst) begin
                    for (int i = 0; i < PIPE; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= s0;
                    for (int i = 1; i < PIPE; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign s_last = pipe_q[PIPE-1];
        end
    endgenerate

    logic          l_act;
    logic          l_hs;
    logic          l_vs;
    logic          l_ls;
    logic          l_fs;
    logic [1:0]    l_mode;
    logic [XW-1:0] l_x;
    logic [YW-1:0] l_y;

    assign {l_act, l_hs, l_vs, l_ls, l_fs, l_mode, l_x, l_y} = s_last;

    logic [23:0] pix;
    logic [31:0] xw;
    logic [31:0] yw;
    logic [2:0]  bar;

    // Colour for the pixel leaving the delay line; anything outside active video is black
    always_comb begin
        pix = 24'h000000;
        xw  = 32'(l_x);
        yw  = 32'(l_y);
        bar = 3'd0;
        case (l_mode)
            2'd0: begin
                if ((xw % 32'd16) == 32'd0 || (yw % 32'd16) == 32'd0) begin
                    pix = 24'hFFFFFF;
                end
            end
            2'd1: begin
                if (xw < 32'(8 * BARW)) begin
                    bar = 3'(xw / 32'(BARD));
                    pix = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
                end
            end
            2'd2:    pix = ext_rgb;
            default: pix = solid_rgb;
        endcase
        if (!l_act) begin
            pix = 24'h000000;
        end
    end

    // Output register: all video signals leave together, sync levels mapped to their polarity
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            vga_hs      <= ~HS_ON;
            vga_vs      <= ~VS_ON;
            vga_blank   <= 1'b0;
            vga_rgb     <= 24'h000000;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_hs      <= l_hs ? HS_ON : ~HS_ON;
            vga_vs      <= l_vs ? VS_ON : ~VS_ON;
            vga_blank   <= l_act;
            vga_rgb     <= pix;
            line_start  <= l_ls;
            frame_start <= l_fs;
        end
    end

endmodule
